// File: rtl/lifo_arbiter.sv
// ---------------------------------------------------------------------------
// lifo_arbiter
// Two-client round-robin arbiter and sequencer in front of an 8-deep LIFO.
//
// The block accepts one push/pop transaction at a time from either client.
// It drives the LIFO write/read strobes and captures popped data. It then
// returns a single response pulse to the client that issued the transaction.
// Operations that cannot be performed are rejected without touching the LIFO:
// a push on a full stack, or a pop on an empty stack. Rejections are counted
// in a saturating counter.
//
// Ports
//   clk            clock, all state on rising edge
//   reset_n        asynchronous active-low reset
//   reqN_valid     request from client N (N = 0,1), held until reqN_ready
//   reqN_op        0 = push, 1 = pop
//   reqN_wdata     push data
//   reqN_ready     one-cycle accept pulse (only ever in IDLE)
//   respN_valid    one-cycle response pulse to client N
//   respN_data     popped data (0 for push or rejected op)
//   respN_err      1 = operation rejected
//   lifo_wn        LIFO write strobe
//   lifo_rn        LIFO read strobe
//   lifo_datain    LIFO write data
//   lifo_dataout   LIFO read data, valid the cycle after lifo_rn
//   lifo_full      LIFO full flag
//   lifo_empty     LIFO empty flag
//   level          stack occupancy as sequenced by this block
//   err_count      rejected-operation counter, saturates at 255
// ---------------------------------------------------------------------------
module lifo_arbiter #(
   parameter int DW    = 8,
   parameter int DEPTH = 8,
   parameter int LW    = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req0_valid,
   input  logic          req0_op,
   input  logic [DW-1:0] req0_wdata,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic          req1_op,
   input  logic [DW-1:0] req1_wdata,
   output logic          req1_ready,
   output logic          resp0_valid,
   output logic [DW-1:0] resp0_data,
   output logic          resp0_err,
   output logic          resp1_valid,
   output logic [DW-1:0] resp1_data,
   output logic          resp1_err,
   output logic          lifo_wn,
   output logic          lifo_rn,
   output logic [DW-1:0] lifo_datain,
   input  logic [DW-1:0] lifo_dataout,
   input  logic          lifo_full,
   input  logic          lifo_empty,
   output logic [LW-1:0] level,
   output logic [7:0]    err_count
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PUSH = 3'd1,
      POP  = 3'd2,
      WAIT = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t        state_reg, state_next;
   logic          rr_reg;
   logic          id_reg;
   logic [DW-1:0] wdata_reg;
   logic [DW-1:0] resp_data_reg;
   logic          resp_err_reg;
   logic [LW-1:0] level_reg;
   logic [7:0]    err_count_reg;

   logic          grant_any;
   logic          grant_id;
   logic          sel_op;
   logic [DW-1:0] sel_wdata;
   logic          reject;

   // Grant selection: a lone requester always wins; a tie goes to the
   // round-robin pointer.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = 1'b0;
      if (state_reg == IDLE) begin
         if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_id  = rr_reg;
         end else if (req0_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
         end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
         end
      end
      sel_op    = grant_id ? req1_op    : req0_op;
      sel_wdata = grant_id ? req1_wdata : req0_wdata;
   end

   // Next-state logic. The LIFO flags are backed up by the locally sequenced
   // level, so a flag glitch can never make the level wrap.
   always_comb begin
      state_next = state_reg;
      reject     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant_any) begin
               if (!sel_op) begin
                  if (lifo_full || (level_reg == LW'(DEPTH))) begin
                     reject     = 1'b1;
                     state_next = RESP;
                  end else begin
                     state_next = PUSH;
                  end
               end else begin
                  if (lifo_empty || (level_reg == '0)) begin
                     reject     = 1'b1;
                     state_next = RESP;
                  end else begin
                     state_next = POP;
                  end
               end
            end
         end
         PUSH:    state_next = RESP;
         POP:     state_next = WAIT;
         WAIT:    state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         rr_reg        <= 1'b0;
         id_reg        <= 1'b0;
         wdata_reg     <= '0;
         resp_data_reg <= '0;
         resp_err_reg  <= 1'b0;
         level_reg     <= '0;
         err_count_reg <= '0;
      end else begin
         state_reg <= state_next;

         if (grant_any) begin
            id_reg    <= grant_id;
            wdata_reg <= sel_wdata;
            rr_reg    <= ~grant_id;
         end

         // Response data/err are loaded only on the edge that enters RESP and
         // then hold until the next transaction reaches RESP.
         if (reject) begin
            resp_err_reg  <= 1'b1;
            resp_data_reg <= '0;
            if (err_count_reg != 8'hFF) begin
               err_count_reg <= err_count_reg + 8'd1;
            end
         end

         case (state_reg)
            PUSH: begin
               if (level_reg != LW'(DEPTH)) begin
                  level_reg <= level_reg + LW'(1);
               end
               resp_err_reg  <= 1'b0;
               resp_data_reg <= '0;
            end
            POP: begin
               if (level_reg != '0) begin
                  level_reg <= level_reg - LW'(1);
               end
            end
            WAIT: begin
               resp_err_reg  <= 1'b0;
               resp_data_reg <= lifo_dataout;
            end
            default: ;
         endcase
      end
   end

   assign req0_ready  = grant_any && !grant_id;
   assign req1_ready  = grant_any &&  grant_id;

   assign lifo_wn     = (state_reg == PUSH);
   assign lifo_rn     = (state_reg == POP);
   assign lifo_datain = (state_reg == PUSH) ? wdata_reg : '0;

   assign resp0_valid = (state_reg == RESP) && !id_reg;
   assign resp1_valid = (state_reg == RESP) &&  id_reg;
   assign resp0_data  = resp_data_reg;
   assign resp1_data  = resp_data_reg;
   assign resp0_err   = resp_err_reg;
   assign resp1_err   = resp_err_reg;

   assign level       = level_reg;
   assign err_count   = err_count_reg;

endmodule
